// File: rtl/bisr_repair_remap.sv
// Purpose: built-in self-repair stage; logs BIST failing addresses into a small
//          fault table, then remaps mission-mode accesses to spare words.
// Latency: 1 cycle (HIT / SPARE_ODATA registered after the sampling edge); no backpressure.
//
// Ports:
//   CLK, RSTN                  clock, synchronous active-low reset
//   BIST_START, BIST_DONE      one-cycle pulses from the BIST FSM
//   FAIL_VLD, FAIL_ADDR        miscompare report from BIST
//   CE, WEB, ADDR, IDATA       mission-mode access (CE high, WEB low = write)
//   HIT, SPARE_ODATA           registered remap result for the previous access
//   REPAIR_CNT                 number of allocated fault-table entries
//   REPAIR_OK, REPAIR_FAIL     REPAIRED / UNREPAIRABLE state flags
module bisr_repair_remap #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int NSPARE = 4
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          BIST_START,
  input  logic                          BIST_DONE,
  input  logic                          FAIL_VLD,
  input  logic [AW-1:0]                 FAIL_ADDR,
  input  logic                          CE,
  input  logic                          WEB,
  input  logic [AW-1:0]                 ADDR,
  input  logic [DW-1:0]                 IDATA,
  output logic                          HIT,
  output logic [DW-1:0]                 SPARE_ODATA,
  output logic [$clog2(NSPARE+1)-1:0]   REPAIR_CNT,
  output logic                          REPAIR_OK,
  output logic                          REPAIR_FAIL
);

  localparam int CW = $clog2(NSPARE+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NSPARE);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    COLLECT      = 2'd1,
    REPAIRED     = 2'd2,
    UNREPAIRABLE = 2'd3
  } state_t;

  state_t              state;
  logic [AW-1:0]       tag   [NSPARE];
  logic [DW-1:0]       spare [NSPARE];
  logic [NSPARE-1:0]   vld;
  logic                ovf;

  // Lookup results for the BIST fail address and the mission access address.
  logic                fail_hit;
  logic [NSPARE-1:0]   acc_match;
  logic                acc_hit;
  logic [DW-1:0]       acc_rdata;
  logic                ovf_nxt;

  always_comb begin
    fail_hit  = 1'b0;
    acc_match = '0;
    acc_rdata = '0;
    for (int i = 0; i < NSPARE; i++) begin
      if (vld[i] && (tag[i] == FAIL_ADDR)) begin
        fail_hit = 1'b1;
      end
      if (vld[i] && (tag[i] == ADDR)) begin
        acc_match[i] = 1'b1;
        // Dedupe guarantees a one-hot match, so OR-reduction is a clean mux.
        acc_rdata    = acc_rdata | spare[i];
      end
    end
    acc_hit = |acc_match;
    // Overflow including a fail arriving in this very cycle, so a
    // simultaneous BIST_DONE sees the updated flag.
    ovf_nxt = ovf | (FAIL_VLD & ~fail_hit & (REPAIR_CNT == CNT_FULL));
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state       <= IDLE;
      vld         <= '0;
      ovf         <= 1'b0;
      REPAIR_CNT  <= '0;
      HIT         <= 1'b0;
      SPARE_ODATA <= '0;
      REPAIR_OK   <= 1'b0;
      REPAIR_FAIL <= 1'b0;
      for (int i = 0; i < NSPARE; i++) begin
        tag[i]   <= '0;
        spare[i] <= '0;
      end
    end else begin
      HIT <= 1'b0;
      if (BIST_START) begin
        // Restart from any state; spare contents are deliberately kept.
        state       <= COLLECT;
        vld         <= '0;
        ovf         <= 1'b0;
        REPAIR_CNT  <= '0;
        REPAIR_OK   <= 1'b0;
        REPAIR_FAIL <= 1'b0;
      end else begin
        case (state)
          COLLECT: begin
            if (FAIL_VLD && !fail_hit && (REPAIR_CNT != CNT_FULL)) begin
              for (int i = 0; i < NSPARE; i++) begin
                if (REPAIR_CNT == CW'(i)) begin
                  tag[i] <= FAIL_ADDR;
                  vld[i] <= 1'b1;
                end
              end
              REPAIR_CNT <= REPAIR_CNT + CW'(1);
            end
            ovf <= ovf_nxt;
            if (BIST_DONE) begin
              if (ovf_nxt) begin
                state       <= UNREPAIRABLE;
                REPAIR_FAIL <= 1'b1;
              end else begin
                state     <= REPAIRED;
                REPAIR_OK <= 1'b1;
              end
            end
          end
          REPAIRED: begin
            if (CE && acc_hit) begin
              HIT <= 1'b1;
              if (!WEB) begin
                for (int i = 0; i < NSPARE; i++) begin
                  if (acc_match[i]) begin
                    spare[i] <= IDATA;
                  end
                end
              end else begin
                SPARE_ODATA <= acc_rdata;
              end
            end
          end
          default: begin
            // IDLE and UNREPAIRABLE: no remapping, table retained.
          end
        endcase
      end
    end
  end

endmodule
